// File: rtl/jt1943_loader_pkg.sv
// jt1943_loader_pkg: loader FSM encoding, PROM bank geometry and SDRAM byte-lane masks
package jt1943_loader_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t HOLD = 2'd3;
  localparam int PROM_BANK_W = 8;
  localparam logic [1:0] MASK_LO = 2'b10;
  localparam logic [1:0] MASK_HI = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;
endpackage

// File: rtl/jt1943_prom_dec.sv
// jt1943_prom_dec: byte address to one-hot PROM write strobe; banks past PROM_CNT decode to nothing
module jt1943_prom_dec
  import jt1943_loader_pkg::*;
#(
  parameter logic [21:0] PROM_START = 22'h4_0000,
  parameter int PROM_CNT = 8
) (
  input  logic                en,
  input  logic [21:0]         addr,
  output logic                is_prom,
  output logic [PROM_CNT-1:0] we
);
  localparam int IW = 22 - PROM_BANK_W;
  logic [IW-1:0] idx;
  assign is_prom = addr >= PROM_START;
  assign idx = is_prom ? IW'((addr - PROM_START) >> PROM_BANK_W) : '0;
  for (genvar g = 0; g < PROM_CNT; g++) begin : g_we
    assign we[g] = en && is_prom && idx == IW'(g);
  end
endmodule

// File: rtl/jt1943_rom_loader.sv
// jt1943_rom_loader: routes the ioctl download stream to paced SDRAM writes and on-chip PROMs.
// Defining JT1943_LOADER_CHECKSUM_EN adds a 16-bit running sum of accepted bytes on chksum.
module jt1943_rom_loader
  import jt1943_loader_pkg::*;
#(
  parameter logic [21:0] PROM_START = 22'h4_0000,
  parameter int PROM_CNT = 8,
  parameter int WE_LEN = 8,
  parameter int RST_EXTRA = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   downloading,
  input  logic                   ioctl_wr,
  input  logic [21:0]            ioctl_addr,
  input  logic [7:0]             ioctl_data,
  output logic                   prog_we,
  output logic [21:0]            prog_addr,
  output logic [7:0]             prog_data,
  output logic [1:0]             prog_mask,
  output logic [PROM_CNT-1:0]    prom_we,
  output logic [PROM_BANK_W-1:0] prom_addr,
  output logic [3:0]             prom_din,
  output logic                   game_rst,
  output logic                   load_done,
  output logic                   overflow
`ifdef JT1943_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]            chksum
`endif
);
  localparam int TW = $clog2(WE_LEN + 1);
  localparam int HW = $clog2(RST_EXTRA + 1);
  state_t st;
  logic dl_q, cap_v, q_v, is_prom, push, pop, accept, enter_load;
  logic [21:0] cap_addr, q_addr;
  logic [7:0] cap_data, q_data;
  logic [TW-1:0] timer;
  logic [HW-1:0] hold_cnt;
  logic [PROM_CNT-1:0] dec_we;

  jt1943_prom_dec #(.PROM_START(PROM_START), .PROM_CNT(PROM_CNT)) u_dec (
    .en(cap_v), .addr(cap_addr), .is_prom(is_prom), .we(dec_we)
  );

  assign enter_load = downloading && !dl_q && st != LOAD;
  assign push = cap_v && !is_prom;
  // prog_we low implies the timer has expired, so an idle cycle separates writes
  assign pop = q_v && !prog_we && (st == LOAD || st == DRAIN);
  assign accept = push && (!q_v || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      dl_q <= 1'b0;
      cap_v <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      q_v <= 1'b0;
      q_addr <= '0;
      q_data <= '0;
      timer <= '0;
      hold_cnt <= '0;
      prog_we <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= MASK_NONE;
      prom_we <= '0;
      prom_addr <= '0;
      prom_din <= '0;
      game_rst <= 1'b1;
      load_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_q <= downloading;
      cap_v <= ioctl_wr && downloading;
      if (ioctl_wr && downloading) begin
        cap_addr <= ioctl_addr;
        cap_data <= ioctl_data;
      end
      prom_we <= dec_we;
      if (|dec_we) begin
        prom_addr <= cap_addr[PROM_BANK_W-1:0];
        prom_din <= cap_data[3:0];
      end
      q_v <= accept || (q_v && !pop);
      if (accept) begin
        q_addr <= cap_addr;
        q_data <= cap_data;
      end
      if (push && !accept) overflow <= 1'b1;
      if (pop) begin
        prog_we <= 1'b1;
        timer <= TW'(WE_LEN - 1);
        prog_addr <= {1'b0, q_addr[21:1]};
        prog_data <= q_data;
        prog_mask <= q_addr[0] ? MASK_HI : MASK_LO;
      end else if (prog_we) begin
        if (timer == '0) prog_we <= 1'b0;
        else timer <= timer - 1'b1;
      end
      load_done <= 1'b0;
      if (enter_load) begin
        st <= LOAD;
        game_rst <= 1'b1;
      end else if (st == LOAD && !downloading) begin
        st <= DRAIN;
      end else if (st == DRAIN && !cap_v && !q_v && !prog_we) begin
        st <= HOLD;
        load_done <= 1'b1;
        hold_cnt <= HW'(RST_EXTRA - 1);
      end else if (st == HOLD) begin
        if (hold_cnt == '0) begin
          st <= IDLE;
          game_rst <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - 1'b1;
        end
      end
    end
  end

`ifdef JT1943_LOADER_CHECKSUM_EN
  // only bytes that actually reach a memory are summed; HOLD/IDLE keep the total frozen
  always_ff @(posedge clk) begin
    if (rst || enter_load) chksum <= '0;
    else if ((accept || |dec_we) && (st == LOAD || st == DRAIN)) chksum <= chksum + 16'(cap_data);
  end
`endif
endmodule

// File: tb/tb_jt1943_rom_loader.sv
// tb_jt1943_rom_loader: randomized scoreboard bench; expected SDRAM/PROM writes are queued at stimulus
// time and popped by a monitor whenever the loader presents a write.
module tb_jt1943_rom_loader;
  localparam int WE_LEN = 8;
  localparam logic [21:0] PSTART = 22'h04_0000;
  logic clk = 1'b0, rst = 1'b1, downloading = 1'b0, ioctl_wr = 1'b0;
  logic [21:0] ioctl_addr = '0;
  logic [7:0] ioctl_data = '0;
  logic prog_we, game_rst, load_done, overflow;
  logic [21:0] prog_addr;
  logic [7:0] prog_data;
  logic [1:0] prog_mask;
  logic [7:0] prom_we, prom_addr;
  logic [3:0] prom_din;
`ifdef JT1943_LOADER_CHECKSUM_EN
  logic [15:0] chksum;
`endif
  int checks = 0, failures = 0;

  typedef struct {logic [21:0] a; logic [7:0] d; logic [1:0] m;} sd_t;
  typedef struct {logic [7:0] we; logic [7:0] a; logic [3:0] d;} pr_t;
  sd_t sdq[$];
  pr_t prq[$];
  logic [15:0] sum = '0;

  jt1943_rom_loader dut (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prom_we(prom_we), .prom_addr(prom_addr), .prom_din(prom_din),
    .game_rst(game_rst), .load_done(load_done), .overflow(overflow)
`ifdef JT1943_LOADER_CHECKSUM_EN
    , .chksum(chksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    failures++;
    $display("FAIL %s got=event exp=none", name);
  endtask

  // reference: a byte below PROM_START becomes one word write, a PROM byte one strobe, else nothing
  task automatic expect_byte(input logic [21:0] a, input logic [7:0] d);
    int idx;
    if (a < PSTART) begin
      sdq.push_back('{a / 2, d, a[0] ? 2'b01 : 2'b10});
      sum += 16'(d);
    end else begin
      idx = int'(a - PSTART) / 256;
      if (idx < 8) begin
        prq.push_back('{8'(1 << idx), a[7:0], d[3:0]});
        sum += 16'(d);
      end
    end
  endtask

  task automatic strobe(input logic [21:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic send(input logic [21:0] a, input logic [7:0] d, input int gap);
    expect_byte(a, d);
    strobe(a, d);
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_we;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (prog_we) return;
    end
    fail_evt("prog_we_timeout");
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sdq.size() == 0 && prq.size() == 0 && !prog_we) return;
    end
    fail_evt("idle_timeout");
  endtask

  int len = 0;
  logic prev_we = 1'b0, unstable = 1'b0;
  logic [21:0] h_addr;
  logic [7:0] h_data;
  logic [1:0] h_mask;
  sd_t cs;
  pr_t cp;

  always @(negedge clk) begin
    if (rst) begin
      len = 0;
      prev_we = 1'b0;
    end else begin
      if (prog_we && !prev_we) begin
        if (sdq.size() == 0) fail_evt("unexpected_prog_we");
        else begin
          cs = sdq.pop_front();
          chk("prog_addr", 32'(prog_addr), 32'(cs.a));
          chk("prog_data", 32'(prog_data), 32'(cs.d));
          chk("prog_mask", 32'(prog_mask), 32'(cs.m));
        end
        h_addr = prog_addr;
        h_data = prog_data;
        h_mask = prog_mask;
        unstable = 1'b0;
        len = 0;
      end
      if (prog_we) begin
        len++;
        if (prog_addr !== h_addr || prog_data !== h_data || prog_mask !== h_mask) unstable = 1'b1;
      end
      if (!prog_we && prev_we) begin
        chk("prog_we_len", 32'(len), 32'(WE_LEN));
        chk("prog_stable", 32'(unstable), 32'd0);
      end
      prev_we = prog_we;
      if (prom_we != '0) begin
        if (prq.size() == 0) fail_evt("unexpected_prom_we");
        else begin
          cp = prq.pop_front();
          chk("prom_we", 32'(prom_we), 32'(cp.we));
          chk("prom_addr", 32'(prom_addr), 32'(cp.a));
          chk("prom_din", 32'(prom_din), 32'(cp.d));
        end
      end
    end
  end

  initial begin
    logic [21:0] a;
    logic [7:0] d0, d1;
    int c, r;
    repeat (2) @(negedge clk);
    chk("rst_prog_we", 32'(prog_we), 32'd0);
    chk("rst_prog_addr", 32'(prog_addr), 32'd0);
    chk("rst_prog_mask", 32'(prog_mask), 32'd3);
    chk("rst_prom_we", 32'(prom_we), 32'd0);
    chk("rst_game_rst", 32'(game_rst), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    downloading = 1'b1;
    sum = '0;
    repeat (3) @(negedge clk);
    chk("load_game_rst", 32'(game_rst), 32'd1);
    send(22'h000010, 8'hAA, 20);
    send(22'h000011, 8'h55, 20);
    send(22'h040105, 8'h3C, 12);
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      a = r < 6 ? 22'($urandom_range(0, 32'h3FFFF)) :
          r < 9 ? PSTART + 22'($urandom_range(0, 32'h7FF)) : 22'($urandom_range(32'h40800, 32'h3FFFFF));
      send(a, 8'($urandom), int'($urandom_range(12, 20)));
    end
    wait_idle();
    send(22'h000020, 8'h77, 0);
    wait_we();
    @(negedge clk);
    downloading = 1'b0;
    c = 0;
    while (!load_done && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("load_done_seen", 32'(load_done), 32'd1);
    chk("done_prog_we", 32'(prog_we), 32'd0);
    chk("done_sd_pending", 32'(sdq.size()), 32'd0);
    chk("done_game_rst", 32'(game_rst), 32'd1);
`ifdef JT1943_LOADER_CHECKSUM_EN
    chk("chksum", 32'(chksum), 32'(sum));
`endif
    c = 0;
    while (c < 100) begin
      @(negedge clk);
      c++;
      if (c == 1) chk("load_done_pulse", 32'(load_done), 32'd0);
      if (!game_rst) break;
    end
    chk("game_rst_hold", 32'(c), 32'd16);
    strobe(22'h000030, 8'h11);
    strobe(22'h040000, 8'h01);
    repeat (20) @(negedge clk);
    chk("idle_game_rst", 32'(game_rst), 32'd0);
    downloading = 1'b1;
    repeat (2) @(negedge clk);
    chk("reload_game_rst", 32'(game_rst), 32'd1);
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    expect_byte(22'h000100, d0);
    expect_byte(22'h000101, d1);
    @(negedge clk);
    ioctl_wr = 1'b1;
    ioctl_addr = 22'h000100;
    ioctl_data = d0;
    @(negedge clk);
    ioctl_addr = 22'h000101;
    ioctl_data = d1;
    @(negedge clk);
    ioctl_addr = 22'h000102;
    ioctl_data = 8'hE7;
    @(negedge clk);
    ioctl_wr = 1'b0;
    wait_idle();
    chk("overflow_set", 32'(overflow), 32'd1);
    repeat (10) @(negedge clk);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    send(22'h000200, 8'h5A, 0);
    wait_we();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    downloading = 1'b0;
    @(negedge clk);
    chk("midrst_prog_we", 32'(prog_we), 32'd0);
    chk("midrst_prog_mask", 32'(prog_mask), 32'd3);
    chk("midrst_game_rst", 32'(game_rst), 32'd1);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("end_sd_pending", 32'(sdq.size()), 32'd0);
    chk("end_prom_pending", 32'(prq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
